// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execution stage: op codes, tag encoding,
// FSM state encoding and the registered result record.
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int MUL_LAT = 32;

  localparam logic [TAG_W-1:0] UNLOCKED = '1;

  localparam logic [OP_W-1:0] OP_ADD    = 6'd0,  OP_SUB   = 6'd1,  OP_AND   = 6'd2;
  localparam logic [OP_W-1:0] OP_OR     = 6'd3,  OP_XOR   = 6'd4,  OP_SLT   = 6'd5;
  localparam logic [OP_W-1:0] OP_SLTU   = 6'd6,  OP_SLL   = 6'd7,  OP_SRL   = 6'd8;
  localparam logic [OP_W-1:0] OP_SRA    = 6'd9,  OP_LUI   = 6'd10, OP_AUIPC = 6'd11;
  localparam logic [OP_W-1:0] OP_JAL    = 6'd12, OP_JALR  = 6'd13;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'd16, OP_BNE   = 6'd17, OP_BLT   = 6'd18;
  localparam logic [OP_W-1:0] OP_BGE    = 6'd19, OP_BLTU  = 6'd20, OP_BGEU  = 6'd21;
  localparam logic [OP_W-1:0] OP_MUL    = 6'd24, OP_MULH  = 6'd25, OP_MULHU = 6'd26;
  localparam logic [OP_W-1:0] OP_MULHSU = 6'd27;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_HOLD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic [4:0]       target;
    logic             br_valid;
    logic             br_taken;
    logic [XLEN-1:0]  br_addr;
    logic             illegal;
  } res_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
  endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// RS-entry / CDB-broadcast bundle between the reservation station, the execution
// unit (slave) and the CDB arbiter.
interface alu_exec_unit_if;
  logic                      rs_busy;
  logic [alu_pkg::OP_W-1:0]  rs_op;
  logic [alu_pkg::XLEN-1:0]  rs_pc;
  logic [alu_pkg::TAG_W-1:0] rs_tagx;
  logic [alu_pkg::TAG_W-1:0] rs_tagy;
  logic [alu_pkg::TAG_W-1:0] rs_tagw;
  logic [alu_pkg::XLEN-1:0]  rs_datax;
  logic [alu_pkg::XLEN-1:0]  rs_datay;
  logic [alu_pkg::XLEN-1:0]  rs_imm;
  logic [4:0]                rs_target;
  logic                      issue_ack;
  logic                      cdb_valid;
  logic                      cdb_grant;
  logic [alu_pkg::TAG_W-1:0] cdb_tag;
  logic [alu_pkg::XLEN-1:0]  cdb_data;
  logic [4:0]                cdb_target;
  logic                      br_valid;
  logic                      br_taken;
  logic [alu_pkg::XLEN-1:0]  br_addr;
  logic                      illegal_op;

  modport slave (
    input  rs_busy, rs_op, rs_pc, rs_tagx, rs_tagy, rs_tagw, rs_datax, rs_datay,
           rs_imm, rs_target, cdb_grant,
    output issue_ack, cdb_valid, cdb_tag, cdb_data, cdb_target, br_valid, br_taken,
           br_addr, illegal_op
  );
  modport master (
    output rs_busy, rs_op, rs_pc, rs_tagx, rs_tagy, rs_tagw, rs_datax, rs_datay,
           rs_imm, rs_target, cdb_grant,
    input  issue_ack, cdb_valid, cdb_tag, cdb_data, cdb_target, br_valid, br_taken,
           br_addr, illegal_op
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per enabled cycle (ALU_MUL_EN builds).
// LAT is expected to equal W: the final step subtracts for a signed multiplier MSB.
module alu_mul_iter import alu_pkg::*; #(
  parameter int W   = XLEN,
  parameter int LAT = MUL_LAT
) (
  input  logic           clk,
  input  logic           en,
  input  logic           abort,
  input  logic           start,
  input  logic           a_signed,
  input  logic           b_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(LAT);

  logic           busy, bsg, last;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand, acc, addend;
  logic [W-1:0]   mplier;

  assign last = (cnt == CW'(LAT - 1));
  assign done = busy & last;

  // product is the accumulator after the current step, so done and product line up
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    product = (last && bsg) ? acc - addend : acc + addend;
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      mplier <= b;
      bsg    <= b_signed;
    end else if (en && busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: issues one ready RS entry, registers its result and holds it on
// the CDB until granted. ALU_MUL_EN adds the iterative multiplier (EXEC state).
module alu_exec_unit (
  input logic            clk,
  input logic            rst,
  input logic            rdy,
  input logic            flush,
  alu_exec_unit_if.slave bus
);
  import alu_pkg::*;

  logic [1:0]      state;
  res_t            res, nres;
  logic            unlocked, issue_ack, is_mul;
  logic [XLEN-1:0] x, y, pc, imm;

  assign x   = bus.rs_datax;
  assign y   = bus.rs_datay;
  assign pc  = bus.rs_pc;
  assign imm = bus.rs_imm;

  assign unlocked  = (bus.rs_tagx == UNLOCKED) && (bus.rs_tagy == UNLOCKED);
  assign issue_ack = !rst && rdy && !flush && bus.rs_busy && unlocked &&
                     (state == ST_IDLE || (state == ST_HOLD && bus.cdb_grant));

  always_comb begin
    nres        = '0;
    nres.tag    = bus.rs_tagw;
    nres.target = bus.rs_target;
    case (bus.rs_op)
      OP_ADD:   nres.data = x + y;
      OP_SUB:   nres.data = x - y;
      OP_AND:   nres.data = x & y;
      OP_OR:    nres.data = x | y;
      OP_XOR:   nres.data = x ^ y;
      OP_SLT:   nres.data = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
      OP_SLTU:  nres.data = {{(XLEN-1){1'b0}}, x < y};
      OP_SLL:   nres.data = x << y[4:0];
      OP_SRL:   nres.data = x >> y[4:0];
      OP_SRA:   nres.data = $unsigned($signed(x) >>> y[4:0]);
      OP_LUI:   nres.data = imm;
      OP_AUIPC: nres.data = pc + imm;
      OP_JAL, OP_JALR: begin
        nres.data     = pc + XLEN'(4);
        nres.br_valid = 1'b1;
        nres.br_taken = 1'b1;
        nres.br_addr  = (bus.rs_op == OP_JAL) ? pc + imm : (x + imm) & ~XLEN'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        nres.tag      = UNLOCKED;
        nres.br_valid = 1'b1;
        nres.br_addr  = pc + imm;
        case (bus.rs_op)
          OP_BEQ:  nres.br_taken = (x == y);
          OP_BNE:  nres.br_taken = (x != y);
          OP_BLT:  nres.br_taken = ($signed(x) <  $signed(y));
          OP_BGE:  nres.br_taken = ($signed(x) >= $signed(y));
          OP_BLTU: nres.br_taken = (x <  y);
          default: nres.br_taken = (x >= y);
        endcase
      end
`ifdef ALU_MUL_EN
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU: ;
`endif
      default:  nres.illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic              mul_done, mul_hi;
  logic [2*XLEN-1:0] mul_prod;

  assign is_mul = is_mul_op(bus.rs_op);

  alu_mul_iter #(.W(XLEN), .LAT(MUL_LAT)) u_mul (
    .clk      (clk),
    .en       (rdy),
    .abort    (flush | rst),
    .start    (issue_ack & is_mul),
    .a_signed (bus.rs_op != OP_MULHU),
    .b_signed (bus.rs_op == OP_MUL || bus.rs_op == OP_MULH),
    .a        (x),
    .b        (y),
    .done     (mul_done),
    .product  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (issue_ack) mul_hi <= (bus.rs_op != OP_MUL);
  end
`else
  assign is_mul = 1'b0;
`endif

  // flush is honoured even while stalled so the multiplier abort and the FSM stay in step
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      res     <= '0;
      res.tag <= UNLOCKED;
    end else if (flush) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      if (issue_ack) begin
        res   <= nres;
        state <= is_mul ? ST_EXEC : ST_HOLD;
      end
`ifdef ALU_MUL_EN
      else if (state == ST_EXEC && mul_done) begin
        res.data <= mul_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
        state    <= ST_HOLD;
      end
`endif
      else if (state == ST_HOLD && bus.cdb_grant) begin
        state <= ST_IDLE;
      end
    end
  end

  assign bus.issue_ack  = issue_ack;
  assign bus.cdb_valid  = (state == ST_HOLD);
  assign bus.cdb_tag    = res.tag;
  assign bus.cdb_data   = res.data;
  assign bus.cdb_target = res.target;
  assign bus.br_valid   = res.br_valid;
  assign bus.br_taken   = res.br_taken;
  assign bus.br_addr    = res.br_addr;
  assign bus.illegal_op = res.illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios then random traffic, every cycle checked
// against an arithmetic reference model of issue, hold/grant and flush behaviour.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  int unsigned total = 0, bad = 0;

  alu_exec_unit_if bus();

  alu_exec_unit dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] ops [25] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL,
                           OP_SRL, OP_SRA, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE,
                           OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_MUL, OP_MULH, OP_MULHU,
                           OP_MULHSU, 6'd63};

  // model: m_hold = result on the CDB, m_exec = multiply cycles still to go
  logic m_hold;
  int   m_exec;
  res_t m_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t ref_res(input logic [5:0] op, input logic [31:0] pc, x, y, imm,
                                   input logic [3:0] tw, input logic [4:0] tg);
    res_t r;
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x);          uy = longint'(y);
    r = '0; r.tag = tw; r.target = tg;
    case (op)
      OP_ADD:   r.data = x + y;
      OP_SUB:   r.data = x - y;
      OP_AND:   r.data = x & y;
      OP_OR:    r.data = x | y;
      OP_XOR:   r.data = x ^ y;
      OP_SLT:   r.data = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU:  r.data = (ux < uy) ? 32'd1 : 32'd0;
      OP_SLL:   begin p = ux << y[4:0]; r.data = p[31:0]; end
      OP_SRL:   begin p = ux >> y[4:0]; r.data = p[31:0]; end
      OP_SRA:   begin p = sx >> y[4:0]; r.data = p[31:0]; end
      OP_LUI:   r.data = imm;
      OP_AUIPC: r.data = pc + imm;
      OP_JAL:   begin r.data = pc + 4; r.br_valid = 1; r.br_taken = 1; r.br_addr = pc + imm; end
      OP_JALR:  begin
        r.data = pc + 4; r.br_valid = 1; r.br_taken = 1;
        r.br_addr = x + imm; r.br_addr[0] = 1'b0;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        r.tag = 4'hF; r.br_valid = 1; r.br_addr = pc + imm;
        case (op)
          OP_BEQ:  r.br_taken = (ux == uy);
          OP_BNE:  r.br_taken = (ux != uy);
          OP_BLT:  r.br_taken = (sx < sy);
          OP_BGE:  r.br_taken = !(sx < sy);
          OP_BLTU: r.br_taken = (ux < uy);
          default: r.br_taken = !(ux < uy);
        endcase
      end
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU: begin
`ifdef ALU_MUL_EN
        case (op)
          OP_MULHU:  p = ux * uy;
          OP_MULHSU: p = sx * uy;
          default:   p = sx * sy;
        endcase
        r.data = (op == OP_MUL) ? p[31:0] : p[63:32];
`else
        r.illegal = 1'b1;
`endif
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  task automatic set_rs(input logic b, input logic [5:0] op, input logic [31:0] x, y, pc, imm,
                        input logic [3:0] tx, ty);
    bus.rs_busy = b; bus.rs_op = op; bus.rs_datax = x; bus.rs_datay = y;
    bus.rs_pc = pc; bus.rs_imm = imm; bus.rs_tagx = tx; bus.rs_tagy = ty;
    bus.rs_tagw = 4'($urandom_range(0, 14)); bus.rs_target = 5'($urandom);
  endtask

  // check at the falling edge, advance the model, return just after the next rising edge
  task automatic cycle();
    logic exp_ack, mul;
    @(negedge clk);
    exp_ack = !rst && rdy && !flush && bus.rs_busy && bus.rs_tagx == 4'hF &&
              bus.rs_tagy == 4'hF && ((!m_hold && m_exec == 0) || (m_hold && bus.cdb_grant));
    chk("issue_ack", bus.issue_ack, exp_ack);
    chk("cdb_valid", bus.cdb_valid, m_hold);
    if (m_hold) begin
      chk("cdb_data",   bus.cdb_data,   m_res.data);
      chk("cdb_tag",    bus.cdb_tag,    m_res.tag);
      chk("cdb_target", bus.cdb_target, m_res.target);
      chk("br_valid",   bus.br_valid,   m_res.br_valid);
      chk("br_taken",   bus.br_taken,   m_res.br_taken);
      chk("br_addr",    bus.br_addr,    m_res.br_addr);
      chk("illegal_op", bus.illegal_op, m_res.illegal);
    end
`ifdef ALU_MUL_EN
    mul = bus.rs_op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
`else
    mul = 1'b0;
`endif
    if (rst || flush) begin
      m_hold = 0; m_exec = 0;
    end else if (rdy) begin
      if (exp_ack) begin
        m_res = ref_res(bus.rs_op, bus.rs_pc, bus.rs_datax, bus.rs_datay, bus.rs_imm,
                        bus.rs_tagw, bus.rs_target);
        if (mul) begin m_exec = MUL_LAT; m_hold = 0; end
        else m_hold = 1;
      end else if (m_exec > 0) begin
        m_exec--;
        if (m_exec == 0) m_hold = 1;
      end else if (m_hold && bus.cdb_grant) begin
        m_hold = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; rdy = 1; flush = 0; bus.cdb_grant = 0;
    set_rs(0, OP_ADD, 0, 0, 0, 0, 4'hF, 4'hF);
    m_hold = 0; m_exec = 0; m_res = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid",  bus.cdb_valid,  0);
    chk("rst_tag",    bus.cdb_tag,    4'hF);
    chk("rst_data",   bus.cdb_data,   0);
    chk("rst_target", bus.cdb_target, 0);
    chk("rst_brv",    bus.br_valid,   0);
    chk("rst_brt",    bus.br_taken,   0);
    chk("rst_braddr", bus.br_addr,    0);
    chk("rst_ill",    bus.illegal_op, 0);
    @(posedge clk); #1;
    rst = 0;

    // ADD back-to-back with grant held
    bus.cdb_grant = 1;
    set_rs(1, OP_ADD, 7, 5, 0, 0, 4'hF, 4'hF);
    repeat (2) cycle();
    bus.rs_busy = 0; cycle();
    // SRA held without grant while another entry waits
    bus.cdb_grant = 0;
    set_rs(1, OP_SRA, 32'h8000_0000, 32'h24, 0, 0, 4'hF, 4'hF);
    cycle();
    set_rs(1, OP_ADD, 1, 2, 0, 0, 4'hF, 4'hF);
    repeat (3) cycle();
    bus.rs_busy = 0; bus.cdb_grant = 1;
    repeat (2) cycle();
    // locked source tag
    set_rs(1, OP_XOR, 32'hF0, 32'h0F, 0, 0, 4'd3, 4'hF);
    repeat (2) cycle();
    bus.rs_tagx = 4'hF; cycle();
    bus.rs_busy = 0; cycle();
    // BLT vs BLTU on -1, 1
    set_rs(1, OP_BLT, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 4'hF, 4'hF); cycle();
    set_rs(1, OP_BLTU, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 4'hF, 4'hF); cycle();
    bus.rs_busy = 0; cycle();
    // flush in HOLD beats grant and a ready entry
    bus.cdb_grant = 0;
    set_rs(1, OP_SUB, 9, 4, 0, 0, 4'hF, 4'hF); cycle();
    flush = 1; bus.cdb_grant = 1; cycle();
    flush = 0; bus.rs_busy = 0; repeat (2) cycle();
    // stall in HOLD ignores grant
    set_rs(1, OP_LUI, 0, 0, 0, 32'h1234_5000, 4'hF, 4'hF); cycle();
    bus.rs_busy = 0; rdy = 0; repeat (2) cycle();
    rdy = 1; repeat (2) cycle();
    // multiplies
    set_rs(1, OP_MUL, 32'hFFFF_FFFD, 7, 0, 0, 4'hF, 4'hF); cycle();
    bus.rs_busy = 0; repeat (MUL_LAT + 2) cycle();
    set_rs(1, OP_MULHU, 32'hFFFF_FFFF, 2, 0, 0, 4'hF, 4'hF); cycle();
    bus.rs_busy = 0; repeat (MUL_LAT + 2) cycle();

    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      rdy           = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      bus.cdb_grant = 1'($urandom);
      set_rs(!rst && ($urandom_range(0, 3) != 0), ops[$urandom_range(0, 24)], rnd_val(),
             rnd_val(), rnd_val(), rnd_val(),
             ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF,
             ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
